// File: rtl/sm_arith_pkg.sv
// Shared sign-magnitude arithmetic definitions for the mul/div blocks.
// Holds the sequencer state encoding, default operand width and sign helpers.
package sm_arith_pkg;

  localparam int SM_DEF_WIDTH = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } sm_state_e;

  // Sign bit of a sign-magnitude word whose sign sits at bit msb.
  function automatic logic sm_sign(input logic [63:0] v, input int unsigned msb);
    return v[msb];
  endfunction

  // A zero magnitude is always reported with a positive sign.
  function automatic logic sm_norm_sign(input logic sign, input logic mag_nz);
    return sign & mag_nz;
  endfunction

endpackage

// File: rtl/sm_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference when it fits.
module sm_div_step #(
  parameter int W = 6
) (
  input  logic [W-2:0] rem_i,
  input  logic         bit_i,
  input  logic [W-2:0] div_i,
  output logic [W-2:0] rem_o,
  output logic         q_o
);

  logic [W-1:0] shifted;

  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {1'b0, div_i});
  // When the subtraction is kept the true result is below the divisor, so the
  // low W-1 bits of the modular difference are exact.
  assign rem_o   = q_o ? (shifted[W-2:0] - div_i) : shifted[W-2:0];

endmodule

// File: rtl/sm_div.sv
// Sequential sign-magnitude divider: 2W-bit dividend / W-bit divisor, one
// quotient bit per clock, start/done handshake; quotient and remainder truncate toward zero.
module sm_div
  import sm_arith_pkg::*;
#(
  parameter int WIDTH = SM_DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quot,
  output logic [WIDTH-1:0]     rem,
  output logic                 ovf,
  output logic                 dz
);

  localparam int DW = 2*WIDTH - 1;
  localparam int MW = WIDTH - 1;
  localparam int CW = $clog2(2*WIDTH);

  sm_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [MW-1:0]    dvs_q, dvs_d;
  logic [MW-1:0]    prem_q, prem_d;
  logic [DW-1:0]    qsh_q, qsh_d;
  logic             sgn_q_q, sgn_q_d;
  logic             sgn_r_q, sgn_r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [MW-1:0]    step_rem;
  logic             step_q;

  sm_div_step #(.W(WIDTH)) u_step (
    .rem_i (prem_q),
    .bit_i (dvd_q[DW-1]),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    qsh_d   = qsh_q;
    sgn_q_d = sgn_q_q;
    sgn_r_d = sgn_r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sgn_q_d = sm_sign(64'(a), DW) ^ sm_sign(64'(b), MW);
          sgn_r_d = sm_sign(64'(a), DW);
          dvd_d   = a[DW-1:0];
          dvs_d   = b[MW-1:0];
          prem_d  = '0;
          qsh_d   = '0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          cnt_d   = CW'(DW);
          state_d = (b[MW-1:0] == '0) ? S_FIN : S_RUN;
        end
      end

      S_RUN: begin
        prem_d = step_rem;
        dvd_d  = {dvd_q[DW-2:0], 1'b0};
        qsh_d  = {qsh_q[DW-2:0], step_q};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dvs_q == '0) begin
          dz_d   = 1'b1;
          ovf_d  = 1'b0;
          quot_d = '0;
          rem_d  = '0;
        end else if (|qsh_q[DW-1:MW]) begin
          // Quotient magnitude does not fit in WIDTH-1 bits.
          ovf_d  = 1'b1;
          quot_d = '0;
          rem_d  = '0;
        end else begin
          quot_d = {sm_norm_sign(sgn_q_q, |qsh_q[MW-1:0]), qsh_q[MW-1:0]};
          rem_d  = {sm_norm_sign(sgn_r_q, |prem_q), prem_q};
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      qsh_q   <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      qsh_q   <= qsh_d;
      sgn_q_q <= sgn_q_d;
      sgn_r_q <= sgn_r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_sm_div.sv
// Scoreboard bench for sm_div: directed corner cases plus randomized operands,
// compared against a plain-integer model of truncating sign-magnitude division.
module tb_sm_div;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic           busy, done, ovf, dz;
  logic [W-1:0]   quot, rem;

  always #5 clk = ~clk;

  sm_div #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .quot  (quot),
    .rem   (rem),
    .ovf   (ovf),
    .dz    (dz)
  );

  typedef struct packed {
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic           ovf;
    logic           dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: integer division of magnitudes, truncation toward zero.
  function automatic exp_t model(input logic [2*W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int am, bm, q, r;
    logic [W-1:0] qv, rv;
    e = '0;
    e.a = av;
    e.b = bv;
    am = int'(av[2*W-2:0]);
    bm = int'(bv[W-2:0]);
    if (bm == 0) begin
      e.dz = 1'b1;
    end else begin
      q = am / bm;
      r = am % bm;
      if (q > (1 << (W-1)) - 1) begin
        e.ovf = 1'b1;
      end else begin
        qv = W'(q);
        rv = W'(r);
        e.quot = {(av[2*W-1] ^ bv[W-1]) && (q != 0), qv[W-2:0]};
        e.rem  = {av[2*W-1] && (r != 0), rv[W-2:0]};
      end
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_pulse_width: done high for 2+ cycles");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: quot=%b rem=%b ovf=%b dz=%b", quot, rem, ovf, dz);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if ({quot, rem, ovf, dz} !== {mon_e.quot, mon_e.rem, mon_e.ovf, mon_e.dz}) begin
          errors++;
          $display("FAIL result a=%b b=%b: got quot=%b rem=%b ovf=%b dz=%b, expected quot=%b rem=%b ovf=%b dz=%b",
                   mon_e.a, mon_e.b, quot, rem, ovf, dz, mon_e.quot, mon_e.rem, mon_e.ovf, mon_e.dz);
        end
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy stuck high");
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Directed op: explicit expectations, plus busy and latency checks.
  // Latency is counted in rising edges after the accepting edge.
  task automatic run_op(input logic [2*W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic eo, input logic ed);
    exp_t e;
    int n;
    wait_idle();
    e = '{a: av, b: bv, quot: eq, rem: er, ovf: eo, dz: ed};
    sb.push_back(e);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_latency", n, ed ? 32'd1 : 32'(2*W));
  endtask

  initial begin
    int n;
    int bm, amax;
    logic [2*W-1:0] ra;
    logic [W-1:0]   rb;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cycles(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_rem",  32'(rem),  32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    check("rst_dz",   32'(dz),   32'd0);
    rst = 1'b0;

    run_op(12'd100, 6'd7, 6'b001110, 6'b000010, 1'b0, 1'b0);
    run_op({1'b1, 11'd100}, 6'd7, 6'b101110, 6'b100010, 1'b0, 1'b0);
    run_op(12'd100, 6'b100111, 6'b101110, 6'b000010, 1'b0, 1'b0);
    run_op(12'd55, 6'b000000, 6'd0, 6'd0, 1'b0, 1'b1);
    run_op(12'd55, 6'b100000, 6'd0, 6'd0, 1'b0, 1'b1);
    run_op({1'b1, 11'd0}, 6'd5, 6'd0, 6'd0, 1'b0, 1'b0);
    run_op(12'd1000, 6'd3, 6'd0, 6'd0, 1'b1, 1'b0);
    run_op(12'd991, 6'd31, 6'd31, 6'd30, 1'b0, 1'b0);
    run_op(12'd992, 6'd31, 6'd0, 6'd0, 1'b1, 1'b0);
    run_op({1'b1, 11'd1}, 6'b100001, 6'b000001, 6'b000000, 1'b0, 1'b0);
    run_op({1'b1, 11'd6}, 6'd3, 6'b100010, 6'b000000, 1'b0, 1'b0);

    // Starts while busy are ignored and input changes after acceptance do nothing.
    wait_idle();
    sb.push_back('{a: 12'd100, b: 6'd7, quot: 6'b001110, rem: 6'b000010, ovf: 1'b0, dz: 1'b0});
    a = 12'd100;
    b = 6'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      start = (n == 1 || n == 5);
      if (n == 3) begin
        a = 12'h7ff;
        b = 6'd1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("ignored_start_latency", n, 32'(2*W));
    cycles(30);
    check("hold_quot", 32'(quot), 32'b001110);
    check("hold_rem", 32'(rem), 32'b000010);
    check("single_done_drained", sb.size(), 32'd0);

    // Reset mid-operation: no done, outputs cleared.
    wait_idle();
    a = 12'd100;
    b = 6'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_quot", 32'(quot), 32'd0);
    check("midrst_rem", 32'(rem), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles(25);
    check("midrst_no_done", 32'(done), 32'd0);
    run_op(12'd100, 6'd7, 6'b001110, 6'b000010, 1'b0, 1'b0);

    // Back-to-back with start held high; operands are random, biased toward non-overflow.
    wait_idle();
    for (int i = 0; i < 2400; i++) begin
      n = 0;
      while (busy && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL b2b_timeout: busy stuck at op %0d", i);
        break;
      end
      rb = W'($urandom_range(0, (1 << W) - 1));
      bm = int'(rb[W-2:0]);
      ra = (2*W)'($urandom_range(0, (1 << (2*W)) - 1));
      if (bm != 0 && $urandom_range(0, 1) == 1) begin
        amax = 32 * bm - 1;
        if (amax > 2047) amax = 2047;
        ra[2*W-2:0] = (2*W-1)'($urandom_range(0, amax));
      end
      if (i % 97 == 0) ra[2*W-2:0] = '0;
      sb.push_back(model(ra, rb));
      a = ra;
      b = rb;
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
